// File: rtl/ppu_bg_pkg.sv
// Shared fetch-state type, VRAM base addresses and dot-window constants
// for the background tile fetch pipeline.
package ppu_bg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    NT_A, NT_D,
    AT_A, AT_D,
    PL_A, PL_D,
    PH_A, PH_D,
    DM_A, DM_D
  } fetch_state_t;

  localparam logic [13:0] NT_BASE = 14'h2000;
  localparam logic [13:0] AT_BASE = 14'h23C0;

  localparam logic [8:0] WIN_FIRST_DOT      = 9'd1;
  localparam logic [8:0] WIN_LAST_DOT       = 9'd256;
  localparam logic [8:0] PREFETCH_FIRST_DOT = 9'd321;
  localparam logic [8:0] DUMMY_FIRST_DOT    = 9'd337;
  localparam logic [8:0] DUMMY_LAST_DOT     = 9'd340;

  // Each attribute byte covers a 2x2 group of quadrants; coarse Y bit 1 and
  // coarse X bit 1 pick the quadrant, two bits per quadrant.
  function automatic logic [2:0] attr_shift(input logic coarse_y_bit1,
                                            input logic coarse_x_bit1);
    return {coarse_y_bit1, coarse_x_bit1, 1'b0};
  endfunction

endpackage

// File: rtl/bg_fetch_addr_gen.sv
// Combinational VRAM address formation for nametable, attribute and
// pattern-table fetches, selected by the fetch state being entered.
module bg_fetch_addr_gen
  import ppu_bg_pkg::*;
(
  input  fetch_state_t state,
  input  logic [14:0]  v_addr,
  input  logic [7:0]   nt_byte,
  input  logic         bg_table_sel,
  output logic [13:0]  addr
);

  logic [13:0] nt_addr;
  logic [13:0] at_addr;
  logic [13:0] pl_addr;

  assign nt_addr = NT_BASE | {2'b00, v_addr[11:0]};
  assign at_addr = AT_BASE | {2'b00, v_addr[11:10], 4'b0000, v_addr[9:7], v_addr[4:2]};
  assign pl_addr = {1'b0, bg_table_sel, nt_byte, 1'b0, v_addr[14:12]};

  always_comb begin
    addr = nt_addr;
    case (state)
      AT_A:    addr = at_addr;
      PL_A:    addr = pl_addr;
      PH_A:    addr = pl_addr | 14'h0008;
      default: addr = nt_addr;
    endcase
  end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: runs the four VRAM fetches per tile on the dot
// schedule and hands finished tiles to the shift-register block.
module bg_tile_fetcher
  import ppu_bg_pkg::*;
#(
  parameter int FETCH_LAST_DOT = 336,
  parameter int PRERENDER_LINE = 261
)
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_EN,
  input  logic        rendering_en,
  input  logic [8:0]  dot,
  input  logic [8:0]  scanline,
  input  logic [14:0] vAddr,
  input  logic        bgTableSel,
  output logic [13:0] vramAddr,
  output logic        vramRead,
  input  logic [7:0]  vramData,
  output logic [7:0]  tileHighByte,
  output logic [7:0]  tileLowByte,
  output logic [1:0]  tileAttr,
  output logic        loadOut,
  output logic        incCoarseX,
  output logic        incY
);

  localparam logic [8:0] FETCH_LAST = 9'(FETCH_LAST_DOT);
  localparam logic [8:0] PRERENDER  = 9'(PRERENDER_LINE);

  fetch_state_t state;
  fetch_state_t next_state;
  logic [2:0]   phase;
  logic         in_window;
  logic         active_line;
  logic         addr_state;
  logic         tile_ok;
  logic [7:0]   nt_byte;
  logic [7:0]   low_stage;
  logic [1:0]   attr_stage;
  logic [2:0]   shift_q;
  logic [13:0]  fetch_addr;

  assign phase       = dot[2:0] - 3'd1;
  assign in_window   = ((dot >= WIN_FIRST_DOT) && (dot <= WIN_LAST_DOT)) ||
                       ((dot >= PREFETCH_FIRST_DOT) && (dot <= FETCH_LAST));
  assign active_line = rendering_en && ((scanline <= 9'd239) || (scanline == PRERENDER));
  assign addr_state  = next_state inside {NT_A, AT_A, PL_A, PH_A, DM_A};

  always_comb begin
    next_state = IDLE;
    if (in_window) begin
      case (phase)
        3'd0:    next_state = NT_A;
        3'd1:    next_state = NT_D;
        3'd2:    next_state = AT_A;
        3'd3:    next_state = AT_D;
        3'd4:    next_state = PL_A;
        3'd5:    next_state = PL_D;
        3'd6:    next_state = PH_A;
        default: next_state = PH_D;
      endcase
    end else if ((dot >= DUMMY_FIRST_DOT) && (dot <= DUMMY_LAST_DOT)) begin
      next_state = dot[0] ? DM_A : DM_D;
    end
  end

  bg_fetch_addr_gen u_addr_gen (
    .state        (next_state),
    .v_addr       (vAddr),
    .nt_byte      (nt_byte),
    .bg_table_sel (bgTableSel),
    .addr         (fetch_addr)
  );

  // tile_ok is set only by a nametable fetch, so a tile joined part-way
  // through (rendering enabled mid-tile, reset release) never loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      vramAddr     <= '0;
      vramRead     <= 1'b0;
      tileHighByte <= '0;
      tileLowByte  <= '0;
      tileAttr     <= '0;
      loadOut      <= 1'b0;
      incCoarseX   <= 1'b0;
      incY         <= 1'b0;
      nt_byte      <= '0;
      low_stage    <= '0;
      attr_stage   <= '0;
      shift_q      <= '0;
      tile_ok      <= 1'b0;
    end else if (clock_EN) begin
      loadOut    <= 1'b0;
      incCoarseX <= 1'b0;
      incY       <= 1'b0;
      if (!active_line) begin
        state    <= IDLE;
        vramRead <= 1'b0;
        tile_ok  <= 1'b0;
      end else begin
        state    <= next_state;
        vramRead <= addr_state;
        if (addr_state) vramAddr <= fetch_addr;
        incY <= (dot == WIN_LAST_DOT);
        case (next_state)
          NT_A: tile_ok <= 1'b1;
          NT_D: nt_byte <= vramData;
          AT_A: shift_q <= attr_shift(vAddr[6], vAddr[1]);
          AT_D: attr_stage <= 2'(vramData >> shift_q);
          PL_D: low_stage <= vramData;
          PH_D: begin
            if (tile_ok && (state == PH_A)) begin
              tileHighByte <= vramData;
              tileLowByte  <= low_stage;
              tileAttr     <= attr_stage;
              loadOut      <= 1'b1;
              incCoarseX   <= 1'b1;
            end
          end
          PL_A, PH_A: ;
          default: tile_ok <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Self-checking bench for bg_tile_fetcher: directed vector table, hand-written
// corner sequences and randomized full lines against an arithmetic model.
module tb_bg_tile_fetcher;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clock_EN;
  logic        rendering_en;
  logic [8:0]  dot;
  logic [8:0]  scanline;
  logic [14:0] vAddr;
  logic        bgTableSel;
  logic [13:0] vramAddr;
  logic        vramRead;
  logic [7:0]  vramData;
  logic [7:0]  tileHighByte;
  logic [7:0]  tileLowByte;
  logic [1:0]  tileAttr;
  logic        loadOut;
  logic        incCoarseX;
  logic        incY;

  logic [7:0] vram [0:16383];
  assign vramData = vram[vramAddr];

  int checks = 0;
  int failures = 0;
  int cntRead, cntLoad, cntIncX, cntIncY, cntDummy;
  logic [7:0] mHigh, mLow;
  logic [1:0] mAttr;

  typedef struct {
    logic [14:0] v;
    logic        bg;
    logic [7:0]  nt, at, pl, ph;
    logic [13:0] ntA, atA, plA, phA;
    logic [1:0]  attr;
  } vec_t;
  vec_t vecs [5];

  bg_tile_fetcher dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN), .rendering_en(rendering_en),
    .dot(dot), .scanline(scanline), .vAddr(vAddr), .bgTableSel(bgTableSel),
    .vramAddr(vramAddr), .vramRead(vramRead), .vramData(vramData),
    .tileHighByte(tileHighByte), .tileLowByte(tileLowByte), .tileAttr(tileAttr),
    .loadOut(loadOut), .incCoarseX(incCoarseX), .incY(incY)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] outVec();
    return {28'd0, vramAddr, vramRead, tileHighByte, tileLowByte, tileAttr,
            loadOut, incCoarseX, incY};
  endfunction

  // kind: 0 nametable, 1 attribute, 2 pattern low, 3 pattern high
  function automatic int fetchAddr(input int v, input int bg, input int kind);
    int nt, at, pl;
    nt = 'h2000 | (v & 'hFFF);
    at = 'h23C0 | (((v >> 10) & 3) << 10) | (((v >> 7) & 7) << 3) | ((v >> 2) & 7);
    pl = (bg << 12) | (int'(vram[14'(nt)]) << 4) | ((v >> 12) & 7);
    case (kind)
      0: return nt;
      1: return at;
      2: return pl;
      default: return pl | 8;
    endcase
  endfunction

  function automatic logic [17:0] tileExpect(input int v, input int bg);
    int sh, attr;
    sh = ((v >> 6) & 1) * 4 + ((v >> 1) & 1) * 2;
    attr = (int'(vram[14'(fetchAddr(v, bg, 1))]) >> sh) & 3;
    return {vram[14'(fetchAddr(v, bg, 3))], vram[14'(fetchAddr(v, bg, 2))], 2'(attr)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d);
    clock_EN = 1'b1;
    dot = 9'(d);
    @(posedge clock);
    #1;
  endtask

  task automatic clearCounts();
    cntRead = 0; cntLoad = 0; cntIncX = 0; cntIncY = 0; cntDummy = 0;
  endtask

  task automatic countDots(input int first, input int last);
    for (int d = first; d <= last; d++) begin
      applyStimulus(d);
      cntRead += int'(vramRead);
      cntLoad += int'(loadOut);
      cntIncX += int'(incCoarseX);
      cntIncY += int'(incY);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    clock_EN = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic runVector(input int i);
    vec_t t;
    t = vecs[i];
    scanline = 9'd0; rendering_en = 1'b1; vAddr = t.v; bgTableSel = t.bg;
    vram[t.ntA] = t.nt; vram[t.atA] = t.at; vram[t.plA] = t.pl; vram[t.phA] = t.ph;
    applyStimulus(0);
    for (int d = 1; d <= 8; d++) begin
      applyStimulus(d);
      case (d)
        1: checkOutput($sformatf("vec%0d.ntAddr", i), {vramRead, vramAddr}, {1'b1, t.ntA});
        3: checkOutput($sformatf("vec%0d.atAddr", i), {vramRead, vramAddr}, {1'b1, t.atA});
        5: checkOutput($sformatf("vec%0d.plAddr", i), {vramRead, vramAddr}, {1'b1, t.plA});
        7: checkOutput($sformatf("vec%0d.phAddr", i), {vramRead, vramAddr}, {1'b1, t.phA});
        default: ;
      endcase
    end
    checkOutput($sformatf("vec%0d.loadPulse", i), {loadOut, incCoarseX}, 2'b11);
    checkOutput($sformatf("vec%0d.high", i), tileHighByte, t.ph);
    checkOutput($sformatf("vec%0d.low", i), tileLowByte, t.pl);
    checkOutput($sformatf("vec%0d.attr", i), tileAttr, t.attr);
    applyStimulus(9);
    checkOutput($sformatf("vec%0d.loadClear", i), {loadOut, incCoarseX}, 2'b00);
  endtask

  task automatic runLine(input int line, input logic ren);
    logic [63:0] expV, maskV, lastExp, lastMask;
    logic        active, inWin, rd, ld, iy;
    int          ph, tv, addr;
    logic [17:0] te;
    scanline = 9'(line); rendering_en = ren; bgTableSel = 1'($urandom_range(0, 1));
    active = ren && (line < 240 || line == 261);
    tv = int'(vAddr);
    lastMask = ~(64'h3FFF << 22);
    lastExp = {28'd0, 14'd0, 1'b0, mHigh, mLow, mAttr, 3'b000};
    clearCounts();
    for (int d = 0; d <= 340; d++) begin
      if ($urandom_range(0, 3) == 0) begin
        clock_EN = 1'b0;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          @(posedge clock);
          #1;
          checkOutput($sformatf("enHold.dot%0d", d), outVec() & lastMask, lastExp);
        end
      end
      inWin = (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
      ph = (d - 1) & 7;
      if (inWin && ph == 0) begin
        vAddr = 15'($urandom);
        tv = int'(vAddr);
      end
      applyStimulus(d);
      rd = 1'b0; ld = 1'b0; iy = 1'b0; addr = 0;
      if (active) begin
        if (inWin && (ph % 2 == 0)) begin
          rd = 1'b1;
          addr = fetchAddr(tv, int'(bgTableSel), ph / 2);
        end else if (d == 337 || d == 339) begin
          rd = 1'b1;
          addr = fetchAddr(tv, int'(bgTableSel), 0);
        end
        ld = inWin && ph == 7;
        iy = (d == 256);
        if (ld) begin
          te = tileExpect(tv, int'(bgTableSel));
          {mHigh, mLow, mAttr} = te;
        end
      end
      expV = {28'd0, rd ? 14'(addr) : 14'd0, rd, mHigh, mLow, mAttr, ld, ld, iy};
      maskV = rd ? ~64'd0 : ~(64'h3FFF << 22);
      checkOutput($sformatf("line%0d.dot%0d", line, d), outVec() & maskV, expV);
      cntRead += int'(vramRead);
      cntLoad += int'(loadOut);
      cntIncX += int'(incCoarseX);
      cntIncY += int'(incY);
      if (d >= 337) cntDummy += int'(vramRead);
      lastExp = expV; lastMask = maskV;
    end
    if (active)
      checkOutput($sformatf("line%0d.counts", line),
                  {8'(cntIncX), 8'(cntIncY), 8'(cntLoad), 8'(cntDummy)},
                  {8'd34, 8'd1, 8'd34, 8'd2});
    else
      checkOutput($sformatf("line%0d.quiet", line),
                  {8'(cntRead), 8'(cntIncX), 8'(cntIncY), 8'(cntLoad)}, 32'd0);
  endtask

  initial begin
    logic [17:0] te;
    int loadsEarly, kind, line;
    logic ren, ld104, ld112;

    reset_n = 1'b0; clock_EN = 1'b0; rendering_en = 1'b0;
    dot = '0; scanline = '0; vAddr = '0; bgTableSel = 1'b0;
    for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);

    vecs[0] = '{15'h0000, 1'b0, 8'h24, 8'h00, 8'hAA, 8'h55, 14'h2000, 14'h23C0, 14'h0240, 14'h0248, 2'd0};
    vecs[1] = '{15'h0042, 1'b0, 8'h24, 8'hC0, 8'hAA, 8'h55, 14'h2042, 14'h23C0, 14'h0240, 14'h0248, 2'd3};
    vecs[2] = '{15'h0000, 1'b0, 8'h24, 8'hC0, 8'hAA, 8'h55, 14'h2000, 14'h23C0, 14'h0240, 14'h0248, 2'd0};
    vecs[3] = '{15'h7000, 1'b1, 8'h24, 8'h1E, 8'h3C, 8'hC3, 14'h2000, 14'h23C0, 14'h1247, 14'h124F, 2'd2};
    vecs[4] = '{15'h3BDF, 1'b0, 8'hFF, 8'h80, 8'h11, 8'h22, 14'h2BDF, 14'h2BFF, 14'h0FF3, 14'h0FFB, 2'd2};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetState", outVec(), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) runVector(i);

    // Asynchronous reset in the middle of a tile, released on a tile boundary.
    scanline = 9'd0; rendering_en = 1'b1; vAddr = 15'h0000; bgTableSel = 1'b0;
    for (int d = 0; d <= 5; d++) applyStimulus(d);
    #2 reset_n = 1'b0;
    #1 checkOutput("resetMidFetch", outVec(), 64'd0);
    for (int d = 6; d <= 8; d++) applyStimulus(d);
    reset_n = 1'b1;
    loadsEarly = 0;
    for (int d = 9; d <= 15; d++) begin
      applyStimulus(d);
      loadsEarly += int'(loadOut);
    end
    checkOutput("resetNoEarlyLoad", 32'(loadsEarly), 32'd0);
    applyStimulus(16);
    checkOutput("resetLoadAt16", loadOut, 1'b1);
    te = tileExpect(0, 0);
    checkOutput("resetTileData", {tileHighByte, tileLowByte, tileAttr}, te);

    // Pulses stretch across disabled cycles.
    scanline = 9'd7;
    for (int d = 0; d <= 8; d++) applyStimulus(d);
    clock_EN = 1'b0;
    repeat (3) @(posedge clock);
    #1 checkOutput("stretchPulses", {loadOut, incCoarseX}, 2'b11);
    applyStimulus(9);
    checkOutput("stretchCleared", {loadOut, incCoarseX}, 2'b00);

    // Idle scanline: no reads, no strobes, tile outputs hold.
    scanline = 9'd240;
    clearCounts();
    countDots(0, 340);
    checkOutput("line240Quiet", {8'(cntRead), 8'(cntLoad), 8'(cntIncX), 8'(cntIncY)}, 32'd0);
    checkOutput("line240Hold", {tileHighByte, tileLowByte, tileAttr}, te);

    // Rendering disabled from dot 100: in-progress tile abandoned.
    scanline = 9'd5; vAddr = 15'h0123; bgTableSel = 1'b0;
    for (int d = 0; d <= 99; d++) applyStimulus(d);
    rendering_en = 1'b0;
    clearCounts();
    countDots(100, 340);
    checkOutput("renderOffQuiet", {8'(cntRead), 8'(cntLoad), 8'(cntIncX), 8'(cntIncY)}, 32'd0);
    checkOutput("renderOffHold", {tileHighByte, tileLowByte, tileAttr}, tileExpect(32'h0123, 0));

    // Rendering enabled mid-tile: the partial tile never loads.
    scanline = 9'd6; vAddr = 15'h0045;
    for (int d = 0; d <= 100; d++) applyStimulus(d);
    rendering_en = 1'b1;
    loadsEarly = 0; ld104 = 1'b0; ld112 = 1'b0;
    for (int d = 101; d <= 112; d++) begin
      applyStimulus(d);
      if (d < 112) loadsEarly += int'(loadOut);
      if (d == 104) ld104 = loadOut;
      if (d == 112) ld112 = loadOut;
    end
    checkOutput("riseNoPartialLoad", {ld104, 8'(loadsEarly)}, 9'd0);
    checkOutput("riseLoadAt112", ld112, 1'b1);
    checkOutput("riseTileData", {tileHighByte, tileLowByte, tileAttr}, tileExpect(32'h0045, 0));

    // Randomized lines against the model.
    doReset();
    mHigh = '0; mLow = '0; mAttr = '0;
    for (int ln = 0; ln < 6; ln++) begin
      kind = (ln < 2) ? 2 : int'($urandom_range(0, 3));
      if (kind == 0) begin
        line = int'($urandom_range(240, 260)); ren = 1'b1;
      end else if (kind == 1) begin
        line = int'($urandom_range(0, 239)); ren = 1'b0;
      end else begin
        line = ($urandom_range(0, 4) == 0) ? 261 : int'($urandom_range(0, 239)); ren = 1'b1;
      end
      runLine(line, ren);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
